// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit for the EX stage of a 32-bit MIPS core.
// Owns HI/LO and sequences MULT/MULTU/DIV/DIVU, one bit per cycle.
// It also serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a result or a HI/LO hazard is pending.
//
// Ports:
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   in_valid           EX holds a valid instruction
//   op, func           instruction[31:26], instruction[5:0]
//   rs_val, rt_val     operands (rs: dividend/multiplicand/MT data, rt: divisor/multiplier)
//   flush              synchronous pipeline flush, aborts any operation
//   stall              hold EX and upstream stages
//   busy               FSM is not IDLE
//   hi, lo             architectural HI/LO registers
//   rdata              MFHI -> hi, MFLO -> lo, otherwise 0
//
// Handshake: a mul/div instruction in EX is accepted in IDLE and then held by
// stall until the FSM reaches DONE. In DONE, stall drops and the instruction
// retires on that edge, together with the HI/LO commit. HI/LO accesses proceed
// only in IDLE.
module mdu_ctrl #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   input  logic [5:0]  op,
   input  logic [5:0]  func,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   // After the counter reaches ITER, one extra edge carries the FSM into DONE.
   // Together with the accept edge, this gives the fixed k+33 DONE / k+34 commit timing.
   localparam logic [5:0] LAST = 6'(ITER);

   state_t      state, state_nx;
   logic [5:0]  cnt;
   logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [31:0] opnd;      // multiplicand magnitude (mul) or divisor magnitude (div)
   logic        neg_res;   // negate product / quotient on commit
   logic        neg_rem;   // negate remainder on commit (follows dividend sign)
   logic        div0;
   logic        is_mul_q;

   // decode
   logic special, is_muldiv, is_hilo, is_mfhi, is_mflo, is_mthi, is_mtlo;
   logic signed_op, mul_op;
   assign special   = (op == 6'b000000);
   assign is_muldiv = special & (func[5:2] == 4'b0110);
   assign is_hilo   = special & (func[5:2] == 4'b0100);
   assign is_mfhi   = is_hilo & (func[1:0] == 2'b00);
   assign is_mthi   = is_hilo & (func[1:0] == 2'b01);
   assign is_mflo   = is_hilo & (func[1:0] == 2'b10);
   assign is_mtlo   = is_hilo & (func[1:0] == 2'b11);
   assign signed_op = ~func[0];
   assign mul_op    = ~func[1];

   logic [31:0] rs_abs, rt_abs;
   assign rs_abs = (signed_op & rs_val[31]) ? (32'd0 - rs_val) : rs_val;
   assign rt_abs = (signed_op & rt_val[31]) ? (32'd0 - rt_val) : rt_val;

   // one shift-add multiply step
   logic [32:0] mul_sum;
   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

   // one restoring-divide step on the 33-bit partial remainder
   logic [32:0] part, diff;
   assign part = {acc[63:32], acc[31]};
   assign diff = part - {1'b0, opnd};

   // commit values
   logic [63:0] prod;
   logic [31:0] quo, rem;
   assign prod = neg_res ? (64'd0 - acc) : acc;
   assign quo  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
   assign rem  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: if (in_valid & is_muldiv) state_nx = mul_op ? MUL : DIV;
            MUL:  if (cnt == LAST) state_nx = DONE;
            // divide-by-zero spends one cycle here, then goes straight to DONE
            DIV:  if (div0 | (cnt == LAST)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         acc      <= 64'd0;
         opnd     <= 32'd0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div0     <= 1'b0;
         is_mul_q <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
      end else begin
         state <= state_nx;
         if (flush) begin
            cnt <= 6'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (in_valid & is_muldiv) begin
                     opnd     <= mul_op ? rs_abs : rt_abs;
                     acc      <= {32'd0, (mul_op ? rt_abs : rs_abs)};
                     neg_res  <= signed_op & (rs_val[31] ^ rt_val[31]);
                     neg_rem  <= signed_op & rs_val[31];
                     div0     <= ~mul_op & (rt_val == 32'd0);
                     is_mul_q <= mul_op;
                     cnt      <= 6'd0;
                  end else if (in_valid & is_mthi) begin
                     hi <= rs_val;
                  end else if (in_valid & is_mtlo) begin
                     lo <= rs_val;
                  end
               end
               MUL: begin
                  if (cnt != LAST) begin
                     acc <= {mul_sum, acc[31:1]};
                     cnt <= cnt + 6'd1;
                  end
               end
               DIV: begin
                  if (!div0 && cnt != LAST) begin
                     acc <= diff[32] ? {part[31:0], acc[30:0], 1'b0}
                                     : {diff[31:0], acc[30:0], 1'b1};
                     cnt <= cnt + 6'd1;
                  end
               end
               DONE: begin
                  if (!div0) begin
                     if (is_mul_q) begin
                        {hi, lo} <= prod;
                     end else begin
                        hi <= rem;
                        lo <= quo;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy  = (state != IDLE);
   assign stall = in_valid & ((is_muldiv & (state != DONE)) | (is_hilo & (state != IDLE)));
   assign rdata = is_mfhi ? hi : (is_mflo ? lo : 32'd0);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic [5:0]  op = 6'd0;
   logic [5:0]  func = 6'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        flush = 1'b0;
   logic        stall, busy;
   logic [31:0] hi, lo, rdata;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

   mdu_ctrl #(.ITER(32)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .op(op), .func(func),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall), .busy(busy),
      .hi(hi), .lo(lo), .rdata(rdata)
   );

   // clock
   always #5 clk = ~clk;

   // Present an instruction just after a rising edge and hold it while stalled.
   // The task returns the number of stalled cycles and rdata from the retiring cycle.
   // The instruction then retires on the following edge.
   task automatic run_op(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, output int ns, output logic [31:0] rd);
      op = o; func = f; rs_val = a; rt_val = b; in_valid = 1'b1; ns = 0;
      @(negedge clk);
      while (stall && ns < 200) begin
         ns++;
         @(negedge clk);
      end
      rd = rdata;
      @(posedge clk); #1;
      in_valid = 1'b0; op = 6'd0; func = 6'd0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
      n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
      n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int ns; logic [31:0] rd;
      run_op(6'd0, F_MULT, 32'hFFFFFFFD, 32'd7, ns, rd);
      n_cmp++; if (ns !== 34) begin n_bad++; $display("FAIL mult_stall got %0d want 34", ns); end
      @(negedge clk);
      n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_after got %b want 0", busy); end
      @(posedge clk); #1;
      run_op(6'd0, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, ns, rd);
      n_cmp++; if (ns !== 34) begin n_bad++; $display("FAIL multu_stall got %0d want 34", ns); end
      n_cmp++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_bad++; $display("FAIL multu_res got %h%h want fffffffe00000001", hi, lo); end
      run_op(6'd0, F_MULT, 32'h80000000, 32'h80000000, ns, rd);
      n_cmp++; if ({hi, lo} !== 64'h40000000_00000000) begin n_bad++; $display("FAIL mult_minmin got %h%h want 4000000000000000", hi, lo); end
   endtask

   task automatic test_div();
      int ns; logic [31:0] rd;
      run_op(6'd0, F_DIV, 32'hFFFFFFF9, 32'd2, ns, rd);
      n_cmp++; if (ns !== 34) begin n_bad++; $display("FAIL div_stall got %0d want 34", ns); end
      n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", lo); end
      n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", hi); end
      run_op(6'd0, F_DIVU, 32'd100, 32'd7, ns, rd);
      n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want 0000000e", lo); end
      n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 00000002", hi); end
      run_op(6'd0, F_DIV, 32'h80000000, 32'hFFFFFFFF, ns, rd);
      n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL div_ovf_hi got %h want 0", hi); end
   endtask

   task automatic test_div0();
      int ns; logic [31:0] rd;
      run_op(6'd0, F_MTHI, 32'h12345678, 32'd0, ns, rd);
      n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL mthi_stall got %0d want 0", ns); end
      run_op(6'd0, F_MTLO, 32'hA5A5A5A5, 32'd0, ns, rd);
      run_op(6'd0, F_MFHI, 32'd0, 32'd0, ns, rd);
      n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL mfhi_rdata got %h want 12345678", rd); end
      run_op(6'd0, F_DIVU, 32'd55, 32'd0, ns, rd);
      n_cmp++; if (ns !== 2) begin n_bad++; $display("FAIL div0_stall got %0d want 2", ns); end
      @(negedge clk);
      n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL div0_hi got %h want 12345678", hi); end
      n_cmp++; if (lo !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL div0_lo got %h want a5a5a5a5", lo); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL div0_busy got %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      int ns; logic [31:0] rd;
      // flush during the tenth iteration
      op = 6'd0; func = F_MULT; rs_val = 32'd5; rt_val = 32'd6; in_valid = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before got %b want 1", busy); end
      flush = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", busy); end
      n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL flush_hi got %h want 12345678", hi); end
      @(posedge clk); #1;
      run_op(6'd0, F_MFLO, 32'd0, 32'd0, ns, rd);
      n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL flush_mflo_stall got %0d want 0", ns); end
      n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL flush_mflo_rdata got %h want a5a5a5a5", rd); end
      // flush in DONE aborts the commit
      op = 6'd0; func = F_MULTU; rs_val = 32'd3; rt_val = 32'd4; in_valid = 1'b1; ns = 0;
      @(negedge clk);
      while (stall && ns < 200) begin ns++; @(negedge clk); end
      flush = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (lo !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL flush_done_lo got %h want a5a5a5a5", lo); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_done_busy got %b want 0", busy); end
      // flush in IDLE blocks an MTLO write
      @(posedge clk); #1;
      op = 6'd0; func = F_MTLO; rs_val = 32'hDEADBEEF; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (lo !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL flush_mtlo got %h want a5a5a5a5", lo); end
      @(posedge clk); #1;
   endtask

   task automatic test_mfhi_busy();
      int ns;
      // DIVU 1000/7 = 142 r 6; MFHI follows it into EX right after the accept edge
      op = 6'd0; func = F_DIVU; rs_val = 32'd1000; rt_val = 32'd7; in_valid = 1'b1; ns = 0;
      @(posedge clk); #1;
      func = F_MFHI;
      @(negedge clk);
      while (stall && ns < 200) begin ns++; @(negedge clk); end
      n_cmp++; if (ns !== 34) begin n_bad++; $display("FAIL mfhi_busy_stall got %0d want 34", ns); end
      n_cmp++; if (rdata !== 32'd6) begin n_bad++; $display("FAIL mfhi_busy_rdata got %h want 00000006", rdata); end
      n_cmp++; if (lo !== 32'd142) begin n_bad++; $display("FAIL mfhi_busy_lo got %h want 0000008e", lo); end
      @(posedge clk); #1;
      in_valid = 1'b0; func = 6'd0;
   endtask

   task automatic test_back_to_back();
      int ns; logic [31:0] rd;
      run_op(6'd0, F_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, ns, rd);
      run_op(6'd0, F_MFLO, 32'd0, 32'd0, ns, rd);
      n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL b2b_mflo_stall got %0d want 0", ns); end
      n_cmp++; if (rd !== 32'h00000001) begin n_bad++; $display("FAIL b2b_mflo_rdata got %h want 00000001", rd); end
      run_op(6'd0, F_MFHI, 32'd0, 32'd0, ns, rd);
      n_cmp++; if (rd !== 32'h3FFFFFFF) begin n_bad++; $display("FAIL b2b_mfhi_rdata got %h want 3fffffff", rd); end
      // non-special opcode with a muldiv func field is ignored
      run_op(6'h08, F_MULT, 32'd9, 32'd9, ns, rd);
      n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL ignored_stall got %0d want 0", ns); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignored_busy got %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      op = 6'd0; func = F_MULT; rs_val = 32'd11; rt_val = 32'd13; in_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL rstmid_hi got %h want 0", hi); end
      n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL rstmid_lo got %h want 0", lo); end
      in_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div0();
      test_flush();
      test_mfhi_busy();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // overall time limit
   initial begin
      #200000;
      $display("FAIL timeout sim_time got %0t want < 200000", $time);
      $fatal(1);
   end

endmodule
